data_mem_responder: RTL

//   Responder end of the core's data-memory port. Accepts one load/store request
//   at a time over a valid/ready handshake, waits a configurable latency and then

---
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after LATENCY wait cycles.
// The word-organised SRAM does byte-lane writes and RV32I-style extension of load results.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbgState
);

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready,
  // a response transfers on a rising edge with resp_valid & resp_ready.
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} stateT;

  stateT       state;
  logic [3:0]  cnt;
  logic        capWe;
  logic [2:0]  capF3;
  logic [31:0] capAddr;
  logic [31:0] capWdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        opWe;
  logic [2:0]  opF3;
  logic [31:0] opAddr;
  logic [31:0] opWdata;
  logic        legal;
  logic        inRange;
  logic        opErr;
  logic        enterResp;
  logic        wrEn;
  logic [IW-1:0] memIdx;
  logic [31:0] memWord;
  logic [31:0] shifted;
  logic [31:0] loadData;
  logic [31:0] wrData;
  logic [3:0]  byteEn;

  assign accept   = req_valid & req_ready;
  assign dbgState = state;

  // With zero latency the operation completes on the accept edge, so it must
  // use the live request fields instead of the captured copies.
  always_comb begin
    opWe    = capWe;
    opF3    = capF3;
    opAddr  = capAddr;
    opWdata = capWdata;
    if (state == IDLE) begin
      opWe    = req_we;
      opF3    = req_funct3;
      opAddr  = req_addr;
      opWdata = req_wdata;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (opF3)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~opAddr[0];
      3'b010:         legal = (opAddr[1:0] == 2'b00);
      3'b100, 3'b101: legal = ~opWe & (opF3[0] ? ~opAddr[0] : 1'b1);
      default:        legal = 1'b0;
    endcase
  end

  assign inRange   = ({2'b00, opAddr[31:2]} < 32'(DEPTH_WORDS));
  assign opErr     = ~legal | ~inRange;
  assign enterResp = (state == IDLE) ? (accept & ZERO_LAT) : ((state == BUSY) && (cnt == 4'd0));
  assign wrEn      = enterResp & opWe & ~opErr;
  assign memIdx    = opAddr[IW+1:2];
  assign memWord   = mem[memIdx];
  assign shifted   = memWord >> {opAddr[1:0], 3'b000};

  always_comb begin
    loadData = '0;
    case (opF3)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  loadData = memWord;
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = '0;
    endcase
  end

  always_comb begin
    wrData = opWdata;
    byteEn = 4'b1111;
    case (opF3[1:0])
      2'b00: begin
        wrData = {4{opWdata[7:0]}};
        byteEn = 4'b0001 << opAddr[1:0];
      end
      2'b01: begin
        wrData = {2{opWdata[15:0]}};
        byteEn = opAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wrData = opWdata;
        byteEn = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[memIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      capWe      <= 1'b0;
      capF3      <= '0;
      capAddr    <= '0;
      capWdata   <= '0;
    end else begin
      if (enterResp) begin
        state      <= RESP;
        req_ready  <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= opErr;
        resp_rdata <= (opErr | opWe) ? 32'd0 : loadData;
      end
      case (state)
        IDLE: begin
          req_ready <= ~accept;
          if (accept) begin
            capWe    <= req_we;
            capF3    <= req_funct3;
            capAddr  <= req_addr;
            capWdata <= req_wdata;
            if (!ZERO_LAT) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
